// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg
//   Shared definitions for the RV32I fetch stage and its pipeline registers:
//   the canonical NOP word, the default reset PC, the fetch FSM state encoding
//   and a word-alignment helper.
package rv32i_fetch_pkg;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // one quiet cycle after reset release
      ST_REQ  = 2'd1,  // request presented, waiting for grant
      ST_WAIT = 2'd2,  // request granted, waiting for the response pulse
      ST_HOLD = 2'd3   // skid buffer full, waiting for decode to drain IF/ID
   } fetch_state_t;

   // Instruction addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/rv32i_if_id_reg.sv
// rv32i_if_id_reg
//   Pipeline register holding one {pc, instr, valid} slot between two stages.
//   Priority: flush > load > stall(hold) > bubble.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     flush             discard the held instruction (becomes NOP, invalid)
//     load              capture load_pc/load_instr as a valid instruction
//     stall             downstream cannot accept; hold the current contents
//     load_pc/instr     incoming instruction
//     pc, instr, valid  register contents
module rv32i_if_id_reg
   import rv32i_fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        stall,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= 32'h0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= load_pc;
         instr <= load_instr;
         valid <= 1'b1;
      end else if (!stall) begin
         // Nothing new arrived and downstream consumed the old slot: bubble.
         // The PC field is left as-is; it is meaningless while valid is low.
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch
//   Fetch stage: owns the architectural PC, issues single-outstanding
//   instruction-memory requests and fills the IF/ID register, with a
//   one-entry skid buffer for responses that arrive while decode stalls.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     next_pc, redirect             control-flow target and its strobe
//     stall                         decode cannot accept; hold IF/ID
//     imem_req, imem_addr, imem_gnt request handshake
//     imem_rvalid, imem_rdata       single-cycle response
//     pc_out, pc_plus4              PC of the current fetch and PC+4
//     if_pc, if_instr, if_valid     IF/ID register
//
//   Memory handshake: a request is transferred on a cycle where imem_req and
//   imem_gnt are both high; imem_addr is held stable while imem_req waits for
//   imem_gnt. Exactly one imem_rvalid pulse follows each transferred request,
//   and no new request is raised until that pulse has been seen.
module rv32i_fetch
   import rv32i_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  addr_q;       // address of the presented request
   logic         kill;         // in-flight response belongs to a dead path
   logic         skid_valid;
   logic [31:0]  skid_pc;
   logic [31:0]  skid_instr;

   logic [31:0]  redirect_pc;
   logic         rsp_live;     // response usable on the current path
   logic         take_rsp;     // response goes straight into IF/ID
   logic         take_skid;    // skid entry drains into IF/ID
   logic         ifid_load;
   logic [31:0]  ifid_load_pc;
   logic [31:0]  ifid_load_instr;

   assign redirect_pc = word_align(next_pc);
   assign rsp_live    = (state == ST_WAIT) && imem_rvalid && !kill && !redirect;
   // Decode only blocks acceptance when IF/ID already holds something.
   assign take_rsp    = rsp_live && (!if_valid || !stall);
   assign take_skid   = (state == ST_HOLD) && skid_valid && !stall && !redirect;

   always_comb begin
      ifid_load       = take_rsp || take_skid;
      ifid_load_pc    = pc;
      ifid_load_instr = imem_rdata;
      if (take_skid) begin
         ifid_load_pc    = skid_pc;
         ifid_load_instr = skid_instr;
      end
   end

   assign imem_req  = (state == ST_REQ);
   assign imem_addr = addr_q;
   assign pc_out    = pc;
   assign pc_plus4  = pc + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         addr_q     <= word_align(RESET_PC);
         kill       <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= NOP_INSTR;
      end else if (redirect) begin
         pc         <= redirect_pc;
         skid_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               state  <= ST_REQ;
               addr_q <= redirect_pc;
            end
            ST_REQ: begin
               // The presented request must complete with its old address;
               // its response is discarded when it arrives.
               kill <= 1'b1;
               if (imem_gnt) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  // Response lands this cycle and is simply dropped.
                  kill   <= 1'b0;
                  state  <= ST_REQ;
                  addr_q <= redirect_pc;
               end else begin
                  kill <= 1'b1;
               end
            end
            ST_HOLD: begin
               state  <= ST_REQ;
               addr_q <= redirect_pc;
            end
            default: state <= ST_IDLE;
         endcase
      end else begin
         case (state)
            ST_IDLE: begin
               state  <= ST_REQ;
               addr_q <= word_align(pc);
            end
            ST_REQ: begin
               if (imem_gnt) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     // pc already points at the redirect target.
                     kill   <= 1'b0;
                     state  <= ST_REQ;
                     addr_q <= word_align(pc);
                  end else if (take_rsp) begin
                     pc     <= pc_plus4;
                     state  <= ST_REQ;
                     addr_q <= word_align(pc_plus4);
                  end else begin
                     skid_valid <= 1'b1;
                     skid_pc    <= pc;
                     skid_instr <= imem_rdata;
                     pc         <= pc_plus4;
                     state      <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  skid_valid <= 1'b0;
                  state      <= ST_REQ;
                  addr_q     <= word_align(pc);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rv32i_if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .load       (ifid_load),
      .stall      (stall),
      .load_pc    (ifid_load_pc),
      .load_instr (ifid_load_instr),
      .pc         (if_pc),
      .instr      (if_instr),
      .valid      (if_valid)
   );

endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch
//   Directed bench for rv32i_fetch followed by a short randomised soak.
//   A transaction-level model of the fetch stage (request pending / response
//   outstanding / drop-next / skid) is stepped on each rising edge and every
//   falling edge a compare process checks the DUT outputs against it.
//   A memory responder inside the driver task grants requests after a
//   configurable delay and returns the word a configurable number of cycles
//   later.
module tb_rv32i_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic [31:0] next_pc = 32'h0;
   logic        redirect = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   rv32i_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .next_pc     (next_pc),
      .redirect    (redirect),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_valid    (if_valid)
   );

   // ---------------- scoreboard counters ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory contents ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         default:       return {a[23:0], 8'h13};
      endcase
   endfunction

   // ---------------- memory responder / driver ----------------
   bit          pend = 0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_cnt = 0;
   int          rsp_lat = 0;     // extra cycles between grant and response
   int          gnt_delay = 0;   // cycles a request waits before the grant
   int          gnt_wait = 0;

   task automatic cyc();
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      imem_gnt    = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 0;
         end else begin
            pend_cnt--;
         end
      end
      if (imem_req && !pend) begin
         if (gnt_wait == 0) begin
            imem_gnt  = 1'b1;
            pend      = 1;
            pend_addr = imem_addr;
            pend_cnt  = rsp_lat;
            gnt_wait  = gnt_delay;
         end else begin
            gnt_wait--;
         end
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_quiet;     // first cycle after reset: no request yet
   bit          m_pend;      // request presented, not yet granted
   bit          m_out;       // request granted, response not yet seen
   bit          m_drop;      // next response belongs to an abandoned path
   bit          m_skid;
   logic [31:0] m_skid_pc, m_skid_instr;
   logic [31:0] m_pc, m_addr;
   bit          m_valid;
   logic [31:0] m_ifpc, m_instr;
   logic [31:0] m_tgt;
   bit          m_loaded;

   task automatic model_reset();
      m_quiet = 1; m_pend = 0; m_out = 0; m_drop = 0; m_skid = 0;
      m_skid_pc = 32'h0; m_skid_instr = NOP;
      m_pc = 32'h0; m_addr = 32'h0;
      m_valid = 0; m_ifpc = 32'h0; m_instr = NOP;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (redirect) begin
         m_tgt   = {next_pc[31:2], 2'b00};
         m_valid = 0;
         m_instr = NOP;
         m_skid  = 0;
         if (m_quiet) begin
            m_quiet = 0; m_pend = 1; m_addr = m_tgt;
         end else if (m_pend) begin
            m_drop = 1;
            if (imem_gnt) begin m_pend = 0; m_out = 1; end
         end else if (m_out && !imem_rvalid) begin
            m_drop = 1;
         end else begin
            // either the response arrives now and is dropped, or the skid is discarded
            m_out = 0; m_drop = 0; m_pend = 1; m_addr = m_tgt;
         end
         m_pc = m_tgt;
      end else begin
         m_loaded = 0;
         if (m_quiet) begin
            m_quiet = 0; m_pend = 1; m_addr = m_pc;
         end else if (m_pend) begin
            if (imem_gnt) begin m_pend = 0; m_out = 1; end
         end else if (m_out && imem_rvalid) begin
            m_out = 0;
            if (m_drop) begin
               m_drop = 0; m_pend = 1; m_addr = m_pc;
            end else if (!m_valid || !stall) begin
               m_ifpc = m_pc; m_instr = imem_rdata; m_valid = 1; m_loaded = 1;
               m_pc = m_pc + 32'd4; m_pend = 1; m_addr = m_pc;
            end else begin
               m_skid = 1; m_skid_pc = m_pc; m_skid_instr = imem_rdata;
               m_pc = m_pc + 32'd4;
            end
         end else if (m_skid && !stall) begin
            m_ifpc = m_skid_pc; m_instr = m_skid_instr; m_valid = 1; m_loaded = 1;
            m_skid = 0; m_pend = 1; m_addr = m_pc;
         end
         if (!m_loaded && !stall) begin
            m_valid = 0; m_instr = NOP;
         end
      end
   endtask

   initial model_reset();

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      check32("pc_out", pc_out, m_pc);
      check32("pc_plus4", pc_plus4, m_pc + 32'd4);
      check32("imem_req", 32'(imem_req), 32'(m_pend));
      if (m_pend) check32("imem_addr", imem_addr, m_addr);
      check32("if_valid", 32'(if_valid), 32'(m_valid));
      check32("if_instr", if_instr, m_instr);
      if (m_valid) check32("if_pc", if_pc, m_ifpc);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      repeat (3) cyc();
      check32("rst_pc", pc_out, 32'h0);
      check32("rst_plus4", pc_plus4, 32'h4);
      check32("rst_req", 32'(imem_req), 32'h0);
      check32("rst_valid", 32'(if_valid), 32'h0);
      check32("rst_instr", if_instr, NOP);
      check32("rst_ifpc", if_pc, 32'h0);
      rst = 1'b0;

      // 1: first fetch from RESET_PC, immediate grant, response next cycle
      cyc();
      check32("t1_req", 32'(imem_req), 32'h1);
      check32("t1_addr", imem_addr, 32'h0);
      cyc();
      cyc();
      check32("t1_ifpc", if_pc, 32'h0);
      check32("t1_instr", if_instr, 32'h0050_0093);
      check32("t1_valid", 32'(if_valid), 32'h1);
      check32("t1_next_addr", imem_addr, 32'h4);
      stall = 1'b1;

      // 2: response for 0x4 arrives while decode stalls -> skid
      cyc();
      cyc();
      check32("t2_hold_req", 32'(imem_req), 32'h0);
      check32("t2_hold_ifpc", if_pc, 32'h0);
      check32("t2_hold_instr", if_instr, 32'h0050_0093);
      check32("t2_hold_valid", 32'(if_valid), 32'h1);
      check32("t2_hold_pc", pc_out, 32'h8);
      cyc();
      check32("t2_hold_req2", 32'(imem_req), 32'h0);
      stall   = 1'b0;
      rsp_lat = 2;
      cyc();
      check32("t2_ifpc", if_pc, 32'h4);
      check32("t2_instr", if_instr, 32'h00A0_0113);
      check32("t2_valid", 32'(if_valid), 32'h1);
      check32("t2_addr", imem_addr, 32'h8);
      check32("t2_req", 32'(imem_req), 32'h1);

      // 3: redirect while waiting for 0x8, response two cycles later
      cyc();
      redirect = 1'b1;
      next_pc  = 32'h0000_0100;
      cyc();
      redirect = 1'b0;
      rsp_lat  = 0;
      check32("t3_pc", pc_out, 32'h100);
      check32("t3_req_wait", 32'(imem_req), 32'h0);
      check32("t3_flush_valid", 32'(if_valid), 32'h0);
      check32("t3_flush_instr", if_instr, NOP);
      cyc();
      cyc();
      check32("t3_req", 32'(imem_req), 32'h1);
      check32("t3_addr", imem_addr, 32'h100);
      check32("t3_valid", 32'(if_valid), 32'h0);
      check32("t3_instr", if_instr, NOP);

      // 4: redirect to unaligned 0x203 coincident with the response
      cyc();
      redirect = 1'b1;
      next_pc  = 32'h0000_0203;
      cyc();
      redirect = 1'b0;
      check32("t4_addr", imem_addr, 32'h200);
      check32("t4_req", 32'(imem_req), 32'h1);
      check32("t4_valid", 32'(if_valid), 32'h0);
      check32("t4_pc", pc_out, 32'h200);
      cyc();
      cyc();
      check32("t4_ifpc", if_pc, 32'h200);
      check32("t4_instr", if_instr, 32'h0002_0013);
      check32("t4_valid", 32'(if_valid), 32'h1);

      // 5: fetch at the top of the address space wraps to 0
      redirect = 1'b1;
      next_pc  = 32'hFFFF_FFFC;
      cyc();
      redirect = 1'b0;
      cyc();
      check32("t5_addr", imem_addr, 32'hFFFF_FFFC);
      check32("t5_pc", pc_out, 32'hFFFF_FFFC);
      check32("t5_plus4", pc_plus4, 32'h0);
      cyc();
      rsp_lat = 4;
      cyc();
      check32("t5_ifpc", if_pc, 32'hFFFF_FFFC);
      check32("t5_instr", if_instr, 32'hFFFF_FC13);
      check32("t5_wrap_pc", pc_out, 32'h0);
      check32("t5_wrap_plus4", pc_plus4, 32'h4);
      check32("t5_wrap_addr", imem_addr, 32'h0);

      // 6: reset while waiting; the late response must be ignored
      cyc();
      #2 rst = 1'b1;
      #1;
      check32("t6_rst_pc", pc_out, 32'h0);
      check32("t6_rst_req", 32'(imem_req), 32'h0);
      check32("t6_rst_valid", 32'(if_valid), 32'h0);
      check32("t6_rst_instr", if_instr, NOP);
      check32("t6_rst_ifpc", if_pc, 32'h0);
      cyc();
      cyc();
      rst       = 1'b0;
      rsp_lat   = 0;
      gnt_delay = 2;
      cyc();
      check32("t6_req", 32'(imem_req), 32'h1);
      check32("t6_addr", imem_addr, 32'h0);
      cyc();
      cyc();
      check32("t6_stray_valid", 32'(if_valid), 32'h0);
      check32("t6_stray_req", 32'(imem_req), 32'h0);
      cyc();
      check32("t6_ifpc", if_pc, 32'h0);
      check32("t6_instr", if_instr, 32'h0050_0093);
      check32("t6_valid", 32'(if_valid), 32'h1);
      check32("t6_pc", pc_out, 32'h4);
      check32("t6_addr_next", imem_addr, 32'h4);

      // 7: redirect while a request waits for its grant
      redirect = 1'b1;
      next_pc  = 32'h0000_0040;
      cyc();
      redirect = 1'b0;
      check32("t7_old_addr", imem_addr, 32'h4);
      check32("t7_req", 32'(imem_req), 32'h1);
      check32("t7_pc", pc_out, 32'h40);
      check32("t7_valid", 32'(if_valid), 32'h0);
      cyc();
      cyc();
      cyc();
      check32("t7_new_addr", imem_addr, 32'h40);
      check32("t7_new_req", 32'(imem_req), 32'h1);
      check32("t7_new_valid", 32'(if_valid), 32'h0);

      // soak: random stall/redirect and memory timing, checked by the model
      for (int i = 0; i < 400; i++) begin
         gnt_delay = $urandom_range(0, 2);
         rsp_lat   = $urandom_range(0, 2);
         stall     = ($urandom_range(0, 2) == 0);
         redirect  = ($urandom_range(0, 7) == 0);
         next_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                 : $urandom;
         cyc();
      end
      redirect = 1'b0;
      stall    = 1'b0;
      repeat (10) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
